// File: rtl/alu_control.sv
// alu_control: registered MIPS ALU-control decoder.
//   Maps the main-control ALU class and the R-type funct field to a 4-bit
//   ALU operation select one clock after the inputs are sampled. Unsupported
//   decodes are flagged, and a saturating debug counter counts them.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-high reset
//   alu_op[1:0]      00 add, 01 subtract, 10 decode by funct, 11 reserved
//   instruction_5_0  funct field
//   in_valid         qualifies alu_op / instruction_5_0
//   alu_out[3:0]     registered ALU operation select
//   out_valid        registered copy of in_valid
//   illegal          registered unsupported-decode flag
//   illegal_cnt      saturating count of accepted illegal decodes
//
// Build option:
//   ALU_CTRL_EXT_EN  also decode addu/subu/xor/sltu for alu_op=10.
//                    When it is not defined, these four codes are illegal.

module alu_control #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       instruction_5_0,
  input  logic             in_valid,
  output logic [3:0]       alu_out,
  output logic             out_valid,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_BAD = 4'b1111;
`ifdef ALU_CTRL_EXT_EN
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b1000;
`endif

  logic [3:0]       alu_out_q, alu_out_d;
  logic             out_valid_q, out_valid_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

  logic [3:0]       dec_op;
  logic             dec_illegal;

  // Pure decode of the current inputs; qualified by in_valid below.
  always_comb begin
    dec_op      = OP_BAD;
    dec_illegal = 1'b1;
    case (alu_op)
      2'b00: begin
        dec_op      = OP_ADD;
        dec_illegal = 1'b0;
      end
      2'b01: begin
        dec_op      = OP_SUB;
        dec_illegal = 1'b0;
      end
      2'b10: begin
        dec_illegal = 1'b0;
        case (instruction_5_0)
          6'b100000: dec_op = OP_ADD;
          6'b100010: dec_op = OP_SUB;
          6'b100100: dec_op = OP_AND;
          6'b100101: dec_op = OP_OR;
          6'b101010: dec_op = OP_SLT;
          6'b100111: dec_op = OP_NOR;
`ifdef ALU_CTRL_EXT_EN
          6'b100001: dec_op = OP_ADD;
          6'b100011: dec_op = OP_SUB;
          6'b100110: dec_op = OP_XOR;
          6'b101011: dec_op = OP_SLTU;
`endif
          default: begin
            dec_op      = OP_BAD;
            dec_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        dec_op      = OP_BAD;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Next state: hold decode outputs when idle, count illegal decodes with saturation.
  always_comb begin
    alu_out_d     = alu_out_q;
    illegal_d     = illegal_q;
    illegal_cnt_d = illegal_cnt_q;
    out_valid_d   = in_valid;
    if (in_valid) begin
      alu_out_d = dec_op;
      illegal_d = dec_illegal;
      if (dec_illegal && (illegal_cnt_q != {CNT_W{1'b1}})) begin
        illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
      end
    end
  end

  // Output registers; reset overrides any decode sampled while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_out_q     <= OP_ADD;
      out_valid_q   <= 1'b0;
      illegal_q     <= 1'b0;
      illegal_cnt_q <= '0;
    end else begin
      alu_out_q     <= alu_out_d;
      out_valid_q   <= out_valid_d;
      illegal_q     <= illegal_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign alu_out     = alu_out_q;
  assign out_valid   = out_valid_q;
  assign illegal     = illegal_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_alu_control.sv
// Directed testbench for alu_control (default CNT_W = 8).
// Inputs are driven 1 ns after a rising edge. Outputs are sampled 1 ns after the next rising edge.

module tb_alu_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] alu_op;
  logic [5:0] instruction_5_0;
  logic       in_valid;
  logic [3:0] alu_out;
  logic       out_valid;
  logic       illegal;
  logic [7:0] illegal_cnt;

  int         vectors = 0;
  int         errors  = 0;
  logic [7:0] exp_cnt;

  alu_control #(.CNT_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .alu_op          (alu_op),
    .instruction_5_0 (instruction_5_0),
    .in_valid        (in_valid),
    .alu_out         (alu_out),
    .out_valid       (out_valid),
    .illegal         (illegal),
    .illegal_cnt     (illegal_cnt)
  );

  always #5 clk = ~clk;

  // Apply one input set and advance to just after the edge that samples it.
  task automatic step(input logic [1:0] op, input logic [5:0] f, input logic v);
    alu_op          = op;
    instruction_5_0 = f;
    in_valid        = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    alu_op = 2'b11; instruction_5_0 = 6'b111111; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (alu_out !== 4'b0010) begin errors++; $display("FAIL reset_alu_out got=%b exp=0010", alu_out); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    vectors++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    vectors++; if (illegal_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", illegal_cnt); end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 8'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_branch;
    step(2'b01, 6'b000000, 1'b1);
    vectors++; if (alu_out !== 4'b0110) begin errors++; $display("FAIL sub_op01 got=%b exp=0110", alu_out); end
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sub_op01_valid got=%b exp=1", out_valid); end
    vectors++; if (illegal !== 1'b0) begin errors++; $display("FAIL sub_op01_illegal got=%b exp=0", illegal); end
    step(2'b00, 6'b000000, 1'b1);
    vectors++; if (alu_out !== 4'b0010) begin errors++; $display("FAIL add_op00 got=%b exp=0010", alu_out); end
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_op00_valid got=%b exp=1", out_valid); end
    vectors++; if (illegal !== 1'b0) begin errors++; $display("FAIL add_op00_illegal got=%b exp=0", illegal); end
    // The funct field is ignored for the load/store and branch classes.
    step(2'b01, 6'b111111, 1'b1);
    vectors++; if (alu_out !== 4'b0110 || illegal !== 1'b0) begin errors++; $display("FAIL sub_op01_funct_ignored got=%b/%b exp=0110/0", alu_out, illegal); end
    step(2'b00, 6'b100010, 1'b1);
    vectors++; if (alu_out !== 4'b0010 || illegal !== 1'b0) begin errors++; $display("FAIL add_op00_funct_ignored got=%b/%b exp=0010/0", alu_out, illegal); end
  endtask

  task automatic test_rtype_sweep;
    logic [5:0] fn [6];
    logic [3:0] ex [6];
    fn[0] = 6'b100000; ex[0] = 4'b0010;
    fn[1] = 6'b100010; ex[1] = 4'b0110;
    fn[2] = 6'b100100; ex[2] = 4'b0000;
    fn[3] = 6'b100101; ex[3] = 4'b0001;
    fn[4] = 6'b101010; ex[4] = 4'b0111;
    fn[5] = 6'b100111; ex[5] = 4'b1100;
    for (int i = 0; i < 6; i++) begin
      step(2'b10, fn[i], 1'b1);
      vectors++; if (alu_out !== ex[i]) begin errors++; $display("FAIL rtype_%b got=%b exp=%b", fn[i], alu_out, ex[i]); end
      vectors++; if (illegal !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL rtype_%b_flags got ill=%b vld=%b exp ill=0 vld=1", fn[i], illegal, out_valid); end
    end
    vectors++; if (illegal_cnt !== exp_cnt) begin errors++; $display("FAIL rtype_cnt got=%0d exp=%0d", illegal_cnt, exp_cnt); end
  endtask

  task automatic test_illegal;
    step(2'b10, 6'b111111, 1'b1);
    exp_cnt = exp_cnt + 8'd1;
    vectors++; if (alu_out !== 4'b1111 || illegal !== 1'b1) begin errors++; $display("FAIL bad_funct got=%b/%b exp=1111/1", alu_out, illegal); end
    vectors++; if (illegal_cnt !== exp_cnt) begin errors++; $display("FAIL bad_funct_cnt got=%0d exp=%0d", illegal_cnt, exp_cnt); end
    step(2'b11, 6'b100000, 1'b1);
    exp_cnt = exp_cnt + 8'd1;
    vectors++; if (alu_out !== 4'b1111 || illegal !== 1'b1) begin errors++; $display("FAIL op11 got=%b/%b exp=1111/1", alu_out, illegal); end
    vectors++; if (illegal_cnt !== 8'd2) begin errors++; $display("FAIL op11_cnt got=%0d exp=2", illegal_cnt); end
  endtask

  task automatic test_hold;
    step(2'b10, 6'b100100, 1'b1);
    vectors++; if (alu_out !== 4'b0000 || illegal !== 1'b0) begin errors++; $display("FAIL hold_setup got=%b/%b exp=0000/0", alu_out, illegal); end
    step(2'b10, 6'b100101, 1'b0);
    vectors++; if (alu_out !== 4'b0000) begin errors++; $display("FAIL hold_alu_out got=%b exp=0000", alu_out); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_out_valid got=%b exp=0", out_valid); end
    vectors++; if (illegal_cnt !== exp_cnt) begin errors++; $display("FAIL hold_cnt got=%0d exp=%0d", illegal_cnt, exp_cnt); end
    step(2'b11, 6'b000000, 1'b1);
    exp_cnt = exp_cnt + 8'd1;
    // An idle cycle with an illegal pattern must neither count nor change the illegal flag.
    step(2'b11, 6'b000000, 1'b0);
    vectors++; if (alu_out !== 4'b1111 || illegal !== 1'b1) begin errors++; $display("FAIL hold_illegal got=%b/%b exp=1111/1", alu_out, illegal); end
    vectors++; if (illegal_cnt !== exp_cnt || out_valid !== 1'b0) begin errors++; $display("FAIL hold_illegal_cnt got=%0d/%b exp=%0d/0", illegal_cnt, out_valid, exp_cnt); end
  endtask

  task automatic test_ext;
    logic [5:0] fn [4];
    logic [3:0] ex [4];
    fn[0] = 6'b100001; ex[0] = 4'b0010;
    fn[1] = 6'b100011; ex[1] = 4'b0110;
    fn[2] = 6'b100110; ex[2] = 4'b0011;
    fn[3] = 6'b101011; ex[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      step(2'b10, fn[i], 1'b1);
`ifdef ALU_CTRL_EXT_EN
      vectors++; if (alu_out !== ex[i] || illegal !== 1'b0) begin errors++; $display("FAIL ext_%b got=%b/%b exp=%b/0", fn[i], alu_out, illegal, ex[i]); end
`else
      exp_cnt = exp_cnt + 8'd1;
      vectors++; if (alu_out !== 4'b1111 || illegal !== 1'b1) begin errors++; $display("FAIL ext_off_%b got=%b/%b exp=1111/1 (non-ext %b)", fn[i], alu_out, illegal, ex[i]); end
`endif
      vectors++; if (illegal_cnt !== exp_cnt) begin errors++; $display("FAIL ext_cnt_%b got=%0d exp=%0d", fn[i], illegal_cnt, exp_cnt); end
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 300; i++) begin
      step(2'b11, 6'(i), 1'b1);
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      vectors++; if (illegal_cnt !== exp_cnt) begin errors++; $display("FAIL sat_cycle%0d got=%0d exp=%0d", i, illegal_cnt, exp_cnt); end
    end
    vectors++; if (illegal_cnt !== 8'd255) begin errors++; $display("FAIL sat_final got=%0d exp=255", illegal_cnt); end
  endtask

  task automatic test_reset_midstream;
    step(2'b10, 6'b101010, 1'b1);
    vectors++; if (alu_out !== 4'b0111) begin errors++; $display("FAIL mid_setup got=%b exp=0111", alu_out); end
    alu_op = 2'b11; instruction_5_0 = 6'b111111; in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    vectors++; if (alu_out !== 4'b0010 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_async got=%b/%b exp=0010/0", alu_out, out_valid); end
    vectors++; if (illegal !== 1'b0 || illegal_cnt !== 8'd0) begin errors++; $display("FAIL mid_async_flags got=%b/%0d exp=0/0", illegal, illegal_cnt); end
    @(posedge clk);
    #1;
    vectors++; if (alu_out !== 4'b0010 || out_valid !== 1'b0 || illegal !== 1'b0 || illegal_cnt !== 8'd0) begin
      errors++; $display("FAIL mid_held got=%b/%b/%b/%0d exp=0010/0/0/0", alu_out, out_valid, illegal, illegal_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 8'd0;
    alu_op = 2'b10; instruction_5_0 = 6'b100111; in_valid = 1'b1;
    @(posedge clk);
    #1;
    vectors++; if (alu_out !== 4'b1100 || out_valid !== 1'b1 || illegal !== 1'b0) begin errors++; $display("FAIL post_reset got=%b/%b/%b exp=1100/1/0", alu_out, out_valid, illegal); end
    vectors++; if (illegal_cnt !== exp_cnt) begin errors++; $display("FAIL post_reset_cnt got=%0d exp=0", illegal_cnt); end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_branch();
    test_rtype_sweep();
    test_illegal();
    test_hold();
    test_ext();
    test_saturation();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
